// File: rtl/pwl_activation_pipe.sv
// rtl/pwl_activation_pipe.sv - three-stage PLAN sigmoid / tanh activation pipeline
// Optional tanh mode is compiled in when PWL_ACT_TANH_EN is defined.
module pwl_activation_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_x,
    input  logic                         in_mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_y,
    output logic                         out_mode
);

    localparam logic signed [DATA_WIDTH-1:0] ONE  = DATA_WIDTH'(1) << FRAC_WIDTH;
    localparam logic signed [DATA_WIDTH-1:0] T1   = ONE;
    localparam logic signed [DATA_WIDTH-1:0] T2   = DATA_WIDTH'(19) << (FRAC_WIDTH - 3);
    localparam logic signed [DATA_WIDTH-1:0] T3   = DATA_WIDTH'(5) << FRAC_WIDTH;
    localparam logic signed [DATA_WIDTH-1:0] I0   = DATA_WIDTH'(1) << (FRAC_WIDTH - 1);
    localparam logic signed [DATA_WIDTH-1:0] I1   = DATA_WIDTH'(5) << (FRAC_WIDTH - 3);
    localparam logic signed [DATA_WIDTH-1:0] I2   = DATA_WIDTH'(27) << (FRAC_WIDTH - 5);
    localparam logic signed [DATA_WIDTH-1:0] MAXV = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] MINV = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic                         adv;
    logic                         v1_q, v2_q, v3_q;
    logic                         neg1_q, neg1_d, neg2_q;
    logic                         mode1_q, mode1_d, mode2_q, mode3_q;
    logic signed [DATA_WIDTH-1:0] x2;
    logic signed [DATA_WIDTH-1:0] a1_q, a1_d;
    logic signed [DATA_WIDTH-1:0] p2_q, p2_d;
    logic signed [DATA_WIDTH-1:0] s3;
    logic signed [DATA_WIDTH-1:0] y3_q, y3_d;

    // One global stall: the whole pipe moves only when the output slot can drain.
    assign adv       = !v3_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = v3_q;
    assign out_y     = y3_q;
    assign out_mode  = mode3_q;

`ifndef PWL_ACT_TANH_EN
    logic mode_unused;
    assign mode_unused = in_mode;
`endif

    always_comb begin
        x2      = in_x;
        mode1_d = 1'b0;
`ifdef PWL_ACT_TANH_EN
        mode1_d = in_mode;
        if (in_mode) begin
            if (in_x[DATA_WIDTH-1] != in_x[DATA_WIDTH-2]) begin
                x2 = in_x[DATA_WIDTH-1] ? MINV : MAXV;
            end else begin
                x2 = in_x <<< 1;
            end
        end
`endif
        neg1_d = x2[DATA_WIDTH-1];
        if (x2 == MINV) begin
            a1_d = MAXV;
        end else if (neg1_d) begin
            a1_d = -x2;
        end else begin
            a1_d = x2;
        end
    end

    always_comb begin
        if (a1_q >= T3) begin
            p2_d = ONE;
        end else if (a1_q >= T2) begin
            p2_d = (a1_q >>> 5) + I2;
        end else if (a1_q >= T1) begin
            p2_d = (a1_q >>> 3) + I1;
        end else begin
            p2_d = (a1_q >>> 2) + I0;
        end
    end

    // Odd symmetry of the sigmoid folds negative inputs; s never exceeds ONE.
    always_comb begin
        s3   = neg2_q ? (ONE - p2_q) : p2_q;
        y3_d = s3;
`ifdef PWL_ACT_TANH_EN
        if (mode2_q) begin
            y3_d = (s3 <<< 1) - ONE;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            neg1_q  <= 1'b0;
            neg2_q  <= 1'b0;
            mode1_q <= 1'b0;
            mode2_q <= 1'b0;
            mode3_q <= 1'b0;
            a1_q    <= '0;
            p2_q    <= '0;
            y3_q    <= '0;
        end else if (adv) begin
            v1_q    <= in_valid;
            v2_q    <= v1_q;
            v3_q    <= v2_q;
            neg1_q  <= neg1_d;
            a1_q    <= a1_d;
            mode1_q <= mode1_d;
            neg2_q  <= neg1_q;
            p2_q    <= p2_d;
            mode2_q <= mode1_q;
            y3_q    <= y3_d;
            mode3_q <= mode2_q;
        end
    end

endmodule

// File: tb/tb_pwl_activation_pipe.sv
// tb/tb_pwl_activation_pipe.sv - directed self-checking bench for pwl_activation_pipe
module tb_pwl_activation_pipe;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [31:0] in_x = '0;
    logic               in_mode = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [31:0] out_y;
    logic               out_mode;

    int tests = 0;
    int fails = 0;

    pwl_activation_pipe #(.DATA_WIDTH(32), .FRAC_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_mode  (out_mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_check(input string tag, input logic signed [31:0] x, input logic m,
                              input logic signed [31:0] ey, input logic em);
        @(negedge clk);
        check({tag, " in_ready"}, in_ready, 1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_x      = x;
        in_mode   = m;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, " early"}, out_valid, 0);
        @(negedge clk);
        check({tag, " valid"}, out_valid, 1);
        check({tag, " y"}, out_y, ey);
        check({tag, " mode"}, out_mode, em);
    endtask

    int tx, rx, both, drops, stale;
    logic stalled;
    logic signed [31:0] held;

    initial begin
        #2;
        check("rst out_valid", out_valid, 0);
        check("rst out_y", out_y, 0);
        check("rst out_mode", out_mode, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst in_ready", in_ready, 1);

        send_check("sig 0", 0, 1'b0, 32768, 1'b0);
        send_check("sig 0.5", 32768, 1'b0, 40960, 1'b0);
        send_check("sig 1.0", 65536, 1'b0, 49152, 1'b0);
        send_check("sig 2.375", 155648, 1'b0, 60160, 1'b0);
        send_check("sig 5.0", 327680, 1'b0, 65536, 1'b0);
        send_check("sig -1.0", -65536, 1'b0, 16384, 1'b0);
        send_check("sig -5.0", -327680, 1'b0, 0, 1'b0);
        send_check("sig min", 32'sh8000_0000, 1'b0, 0, 1'b0);
        send_check("sig max", 32'sh7fff_ffff, 1'b0, 65536, 1'b0);

`ifdef PWL_ACT_TANH_EN
        send_check("tanh 0.5", 32768, 1'b1, 32768, 1'b1);
        send_check("tanh -0.5", -32768, 1'b1, -32768, 1'b1);
        send_check("tanh 0", 0, 1'b1, 0, 1'b1);
        send_check("tanh 5.0", 327680, 1'b1, 65536, 1'b1);
`else
        send_check("tanh 0.5", 32768, 1'b1, 40960, 1'b0);
        send_check("tanh -0.5", -32768, 1'b1, 24576, 1'b0);
        send_check("tanh 0", 0, 1'b1, 32768, 1'b0);
        send_check("tanh 5.0", 327680, 1'b1, 65536, 1'b0);
`endif

        // Backpressure: ten samples x = k*4096 map to 32768 + 1024*k.
        tx = 0; rx = 0; both = 0; drops = 0; stalled = 1'b0; held = '0;
        for (int c = 0; c < 40 && rx < 10; c++) begin
            @(negedge clk);
            if (stalled) check("bp stable", out_y, held);
            out_ready = !(c >= 4 && c <= 8);
            in_valid  = (tx < 10);
            in_x      = 32'(tx * 4096);
            in_mode   = 1'b0;
            #1;
            check("bp in_ready", in_ready, !out_valid || out_ready);
            if (!in_ready) drops++;
            if (out_valid && out_ready) begin
                check("bp data", out_y, 32768 + 1024 * rx);
                rx++;
            end
            if (in_valid && in_ready) tx++;
            if (out_valid && out_ready && in_valid && in_ready) both++;
            stalled = out_valid && !out_ready;
            held    = out_y;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp rx count", rx, 10);
        check("bp tx count", tx, 10);
        check("bp pop+push seen", both > 0, 1);
        check("bp in_ready dropped", drops > 0, 1);
        stale = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("bp no duplicate", stale, 0);

        // Reset with three samples in flight.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_x     = 32'(65536 * (k + 1));
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("rs full pipe", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("rs out_valid async", out_valid, 0);
        check("rs out_y async", out_y, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rs in_ready", in_ready, 1);
        stale = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("rs no stale", stale, 0);
        send_check("rs first new", 65536, 1'b0, 49152, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
